// File: rtl/calc_pkg.sv
// Shared types and encodings for the calculator sequencer: the FSM state set,
// the ALU op codes and the phase indication shown to the user.
package calc_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_REM = 2'b11;

    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_OP   = 2'd2;
    localparam logic [1:0] PH_EXEC = 2'd3;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            WAIT_A:  phase_of = PH_A;
            WAIT_B:  phase_of = PH_B;
            WAIT_OP: phase_of = PH_OP;
            default: phase_of = PH_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/calc_seq.sv
// Operand/op entry sequencer for an external ALU: collects A, B and an op code,
// waits ALU_LAT cycles, then captures the ALU result and flags for display.
module calc_seq
    import calc_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       enter,
    input  logic [2:0] din,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [3:0] alu_r,
    input  logic       alu_sf,
    input  logic       alu_zf,
    input  logic       alu_dzf,
    output logic [3:0] result,
    output logic       sign,
    output logic       zero,
    output logic       dz_err,
    output logic [1:0] phase,
    output logic       done
);

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t     state_q, state_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic       sign_q, sign_d;
    logic       zero_q, zero_d;
    logic       dz_q, dz_d;
    logic       done_q, done_d;
    logic [1:0] phase_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        case (state_q)
            WAIT_A, SHOW: begin
                if (enter) begin
                    a_d     = din;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (enter) begin
                    b_d     = din;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (enter) begin
                    op_d    = din[1:0];
                    cnt_d   = LAT_CNT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // Last EXEC cycle: a divide-by-zero overrides whatever the ALU drives.
                if (cnt_q == 4'd1) begin
                    result_d = alu_dzf ? 4'd0 : alu_r;
                    sign_d   = alu_dzf ? 1'b0 : alu_sf;
                    zero_d   = alu_dzf ? 1'b0 : alu_zf;
                    dz_d     = alu_dzf;
                    done_d   = 1'b1;
                    state_d  = SHOW;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    // clr shares the reset path so that a clear always beats a same-cycle enter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= WAIT_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            phase_q  <= PH_A;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            phase_q  <= phase_of(state_d);
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_s  = op_q;
    assign result = result_q;
    assign sign   = sign_q;
    assign zero   = zero_q;
    assign dz_err = dz_q;
    assign phase  = phase_q;
    assign done   = done_q;

endmodule
